cpu_control_fsm: RTL
====================

# cpu_control_fsm

Parametrised instruction-sequencing controller for the CPU core, successor to the fixed four-cycle fetch/decode/execute sequencer. Drives instruction ROM reads through a valid handshake, latches the instruction register, and executes for an opcode-dependent number of cycles. Updates the PC with wrap-around, jump and conditional branch, and supports stall and halt. Sits between the instruction ROM and the datapath control decoder.

## Interface
- PC_W, 8, program counter and ROM address width
- INSTR_W, 16, instruction width; opcode is ir[INSTR_W-1 -: 4], branch target is ir[PC_W-1:0] (requires INSTR_W >= PC_W+4)
- EXEC_MAX, 4, maximum execute cycles; exec_step width is clog2(EXEC_MAX)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run  in  1  1 = advance, 0 = freeze all state (stall)
- rom_valid  in  1  rom_data valid this cycle
- rom_data  in  INSTR_W  instruction word from ROM
- zero_flag  in  1  datapath zero flag, used by BRZ
- resume  in  1  leave HALT
- rom_read_enable  out  1  ROM read request
- rom_addr  out  PC_W  equals pc
- ir  out  INSTR_W  instruction register
- ir_load  out  1  one-cycle pulse when ir is updated
- state  out  3  current state encoding
- exec_step  out  clog2(EXEC_MAX)  execute cycle index, 0-based
- pc  out  PC_W  program counter
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: FETCH=0, WAIT=1, DECODE=2, EXEC=3, HALT=4. Encodings 5-7 are unreachable and go to FETCH.
- Reset (async): pc=0, state=FETCH, ir=0, exec_step=0, ir_load=0, illegal=0, halted=0. rom_read_enable is 0 during reset.
- rom_read_enable = (state==FETCH or WAIT) and run. It is Moore-decoded and not registered.
- FETCH / WAIT:
  - If rom_valid: ir<=rom_data, ir_load pulses (registered, high during the DECODE cycle), next state DECODE.
  - Else: next state WAIT. There is no timeout.
- DECODE: length L from the opcode table; exec_step<=0; illegal pulses (registered, high during the first EXEC cycle) for undefined opcodes. HALT opcode goes to HALT, all others go to EXEC.
- Opcode table:
  - 0 NOP: L=1
  - 1-7 ALU: L=2
  - 8 LOAD: L=3
  - 9 STORE: L=3
  - 10 JMP: L=1
  - 11 BRZ: L=2
  - 15 HALT
  - 12-14 illegal: executed as NOP, L=1
  - All L values are <= EXEC_MAX; L is clamped to EXEC_MAX if EXEC_MAX is overridden smaller.
- EXEC: exec_step increments each cycle. On the cycle where exec_step==L-1:
  - JMP: pc<=target.
  - BRZ: pc<=target if zero_flag (sampled that cycle), else pc+1.
  - All others: pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0).
  - Next state is FETCH and exec_step returns to 0.
- HALT: halted=1 and pc is held. When resume: pc<=pc+1, next state FETCH. resume has no effect outside HALT.

## Timing
- run=0 freezes state, pc, ir and exec_step. Pulse outputs drop to 0. rom_valid is ignored while run=0, so the ROM must hold rom_data/rom_valid until a cycle where run=1.
- With a zero-wait ROM (rom_valid in the FETCH cycle), an instruction takes L+2 cycles. Each extra ROM wait cycle adds one WAIT cycle.
- The new pc is visible in the first FETCH cycle after the final EXEC cycle. rom_addr follows pc with no delay.
- Simultaneous run=0 and last EXEC cycle: the freeze wins; pc updates on the next cycle with run=1.
- resume together with run=0 is ignored.
- Reset mid-EXEC or in WAIT aborts immediately with no partial pc update.

## Structure
- Package cpu_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - exec-length function (opcode -> L, illegal flag)
- One sub-module, cpu_opcode_decode (combinational: opcode in, L/is_jmp/is_brz/is_halt/illegal out), instantiated once.
- The rest is a single sequential process plus Moore output decode.

## Test plan
- Reset then zero-wait ROM returning NOP (0x0000) at every address -> pc steps 0,1,2 every 3 cycles; ir_load pulses once per instruction.
- ROM asserts rom_valid 2 cycles late for LOAD (0x8000) -> FETCH, WAIT, WAIT, DECODE, 3 EXEC; pc 0->1 after 7 cycles.
- JMP 0xA0F0 at pc=3 -> pc=0xF0; BRZ 0xB020 with zero_flag=0 -> pc+1; with zero_flag=1 -> pc=0x20.
- pc=0xFF executing NOP -> pc wraps to 0x00; opcode 0xC -> illegal pulses once, pc+1.
- HALT (0xF000) at pc=5 -> halted=1 and pc holds 5 for 10 cycles; resume -> pc=6, FETCH.
- run=0 held 3 cycles during EXEC of an ALU op, and reset asserted mid-WAIT -> exec_step/pc frozen during the stall; after reset all outputs hold their reset values and pc=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encodings, opcode constants and the opcode -> execute-length decode shared by the sequencer.
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_JMP = 4'd10;
  localparam logic [3:0] OP_BRZ = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;
  typedef struct packed {
    logic [3:0] len;
    logic       jmp;
    logic       brz;
    logic       halt;
    logic       illegal;
  } dec_t;
  // Undefined opcodes 12-14 run as a one-cycle NOP; lengths clamp to emax.
  function automatic dec_t exec_len(input logic [3:0] op, input int emax);
    dec_t d;
    int l;
    l = (op == OP_NOP || op == OP_JMP || op >= 4'd12) ? 1 :
        (op inside {[4'd1:4'd7]} || op == OP_BRZ) ? 2 : 3;
    d.len = 4'(l > emax ? emax : l);
    d.jmp = op == OP_JMP;
    d.brz = op == OP_BRZ;
    d.halt = op == OP_HALT;
    d.illegal = op inside {[4'd12:4'd14]};
    return d;
  endfunction
endpackage

// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: instruction ROM read bus.
//   rom_read_enable/rom_addr: controller -> ROM; rom_valid/rom_data: ROM -> controller.
interface cpu_control_fsm_if #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16
);
  logic               rom_read_enable;
  logic [PC_W-1:0]    rom_addr;
  logic               rom_valid;
  logic [INSTR_W-1:0] rom_data;
  modport master (output rom_read_enable, rom_addr, input rom_valid, rom_data);
  modport slave (input rom_read_enable, rom_addr, output rom_valid, rom_data);
endinterface

// File: rtl/cpu_opcode_decode.sv
// cpu_opcode_decode: combinational opcode decode.
//   op in; len (execute cycles), is_jmp, is_brz, is_halt, illegal out.
module cpu_opcode_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int EXEC_MAX = 4
) (
  input  logic [3:0] op,
  output logic [3:0] len,
  output logic       is_jmp,
  output logic       is_brz,
  output logic       is_halt,
  output logic       illegal
);
  assign {len, is_jmp, is_brz, is_halt, illegal} = exec_len(op, EXEC_MAX);
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: fetch/wait/decode/execute/halt instruction sequencer.
//   clk, reset (async, active-high), run (0 = stall), zero_flag (BRZ), resume (leave HALT);
//   rom: ROM read bus; ir/ir_load: instruction register and load pulse;
//   state, exec_step, pc, halted, illegal: sequencer status.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter int EXEC_MAX = 4,
  localparam int SW = EXEC_MAX > 1 ? $clog2(EXEC_MAX) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               zero_flag,
  input  logic               resume,
  cpu_control_fsm_if.master  rom,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_load,
  output logic [2:0]         state,
  output logic [SW-1:0]      exec_step,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               illegal
);
  state_t             st, st_n;
  logic [PC_W-1:0]    pc_n;
  logic [INSTR_W-1:0] ir_n;
  logic [SW-1:0]      step_n;
  logic               ir_load_n, illegal_n;
  logic [3:0]         len;
  logic               is_jmp, is_brz, is_halt, is_ill, last;
  // ir is stable from DECODE through EXEC, so the decode is taken straight off it.
  cpu_opcode_decode #(.EXEC_MAX(EXEC_MAX)) u_dec (
    .op(ir[INSTR_W-1 -: 4]),
    .len(len),
    .is_jmp(is_jmp),
    .is_brz(is_brz),
    .is_halt(is_halt),
    .illegal(is_ill)
  );
  assign last = 32'(exec_step) == 32'(len) - 32'd1;
  always_comb begin
    st_n = st;
    pc_n = pc;
    ir_n = ir;
    step_n = exec_step;
    ir_load_n = 1'b0;
    illegal_n = 1'b0;
    if (run) begin
      case (st)
        FETCH, WAIT: begin
          st_n = rom.rom_valid ? DECODE : WAIT;
          ir_n = rom.rom_valid ? rom.rom_data : ir;
          ir_load_n = rom.rom_valid;
        end
        DECODE: begin
          step_n = '0;
          illegal_n = is_ill;
          st_n = is_halt ? HALT : EXEC;
        end
        EXEC: begin
          step_n = last ? '0 : exec_step + 1'b1;
          st_n = last ? FETCH : EXEC;
          pc_n = !last ? pc : (is_jmp || (is_brz && zero_flag)) ? ir[PC_W-1:0] : pc + 1'b1;
        end
        HALT: begin
          st_n = resume ? FETCH : HALT;
          pc_n = resume ? pc + 1'b1 : pc;
        end
        default: st_n = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= FETCH;
      pc <= '0;
      ir <= '0;
      exec_step <= '0;
      ir_load <= 1'b0;
      illegal <= 1'b0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      ir <= ir_n;
      exec_step <= step_n;
      ir_load <= ir_load_n;
      illegal <= illegal_n;
    end
  end
  assign state = st;
  assign halted = st == HALT;
  assign rom.rom_read_enable = !reset && run && (st == FETCH || st == WAIT);
  assign rom.rom_addr = pc;
endmodule
